// File: rtl/fft_out_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_out_pkg
// Description : Shared constants for the FFT/IFFT output sequencer: state
//               encoding, default frame geometry and counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_out_pkg;

    // Frame geometry defaults: 8 groups of 8 words make one 64-point frame.
    localparam int c_num_seg_default = 8;
    localparam int c_num_grp_default = 8;

    // Width of the word and group counters (and of the grp_idx port).
    localparam int c_cnt_w = 3;

    // Sequencer state encoding.
    localparam int c_st_w = 2;
    localparam logic [c_st_w-1:0] c_st_idle  = 2'd0;
    localparam logic [c_st_w-1:0] c_st_load  = 2'd1;
    localparam logic [c_st_w-1:0] c_st_shift = 2'd2;
    localparam logic [c_st_w-1:0] c_st_done  = 2'd3;

endpackage : fft_out_pkg
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter
// Description : Saturating modulo counter with synchronous clear, count
//               enable and terminal-count flag. The count stops at
//               MODULUS-1 instead of wrapping; the owner clears it.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_counter #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8
) (
    input  logic             clk,
    input  logic             rst,       // asynchronous, active-low
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    // Last value before the counter would leave its range.
    localparam logic [WIDTH-1:0] c_last = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_cnt;
    logic             w_tc;

    // Terminal count flag: the counter sits on its last legal value.
    always_comb begin
        w_tc = (r_cnt == c_last);
    end

    // Count register: clear wins over enable, and the count holds at the
    // terminal value rather than wrapping back to zero mid-frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !w_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_count = r_cnt;
    assign o_tc    = w_tc;

endmodule : mod_counter
`default_nettype wire

// File: rtl/output_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : output_sequencer
// Description : Drives the parallel-load / shift output chain of the FFT
//               core. Each frame is NUM_GRP groups; each group is loaded in
//               one cycle and then shifted out NUM_SEG words under
//               out_ready back-pressure. Control outputs are pure decodes of
//               state and inputs, so they respond in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module output_sequencer
    import fft_out_pkg::*;
#(
    parameter int NUM_SEG = c_num_seg_default,
    parameter int NUM_GRP = c_num_grp_default
) (
    input  logic               clk,
    input  logic               rst,             // asynchronous, active-low
    input  logic               start,
    input  logic               mode_in,
    input  logic               abort,
    input  logic               out_ready,
    output logic               in_ctrl_all_seg,
    output logic               hold_all_seg,
    output logic               mode,
    output logic               out_valid,
    output logic [c_cnt_w-1:0] grp_idx,
    output logic               busy,
    output logic               frame_done
);

    logic [c_st_w-1:0]  r_state;
    logic [c_st_w-1:0]  w_next_state;
    logic               r_mode;

    logic [c_cnt_w-1:0] w_word_cnt;
    logic               w_word_tc;
    logic [c_cnt_w-1:0] w_grp_cnt;
    logic               w_grp_tc;

    logic               w_frame_start;
    logic               w_word_clear;
    logic               w_word_en;
    logic               w_grp_clear;
    logic               w_grp_en;

    // Counter control: a new frame starts only from IDLE and only when not
    // cancelled in the same cycle; the word count restarts for every group.
    always_comb begin
        w_frame_start = (r_state == c_st_idle) && start && !abort;
        w_word_clear  = abort || (r_state != c_st_shift);
        w_word_en     = (r_state == c_st_shift) && out_ready;
        w_grp_clear   = abort || w_frame_start;
        w_grp_en      = (r_state == c_st_shift) && out_ready && w_word_tc;
    end

    // Word position inside the current group.
    mod_counter #(
        .WIDTH   (c_cnt_w),
        .MODULUS (NUM_SEG)
    ) u_word_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_word_clear),
        .i_enable (w_word_en),
        .o_count  (w_word_cnt),
        .o_tc     (w_word_tc)
    );

    // Group index inside the current frame.
    mod_counter #(
        .WIDTH   (c_cnt_w),
        .MODULUS (NUM_GRP)
    ) u_grp_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_grp_clear),
        .i_enable (w_grp_en),
        .o_count  (w_grp_cnt),
        .o_tc     (w_grp_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Mode is captured only on the IDLE->LOAD transition so that a start
    // pulse seen mid-frame cannot disturb the swap/scale stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode <= 1'b0;
        end else if (w_frame_start) begin
            r_mode <= mode_in;
        end
    end

    // Next-state logic; abort overrides every other input.
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        w_next_state = c_st_load;
                    end
                end
                c_st_load: begin
                    w_next_state = c_st_shift;
                end
                c_st_shift: begin
                    if (out_ready && w_word_tc) begin
                        w_next_state = w_grp_tc ? c_st_done : c_st_load;
                    end
                end
                c_st_done: begin
                    w_next_state = c_st_idle;
                end
                default: begin
                    w_next_state = c_st_idle;
                end
            endcase
        end
    end

    // Output decode. The chain is frozen by default; it moves only on the
    // load cycle and on accepted words that are not the last of a group
    // (the last accepted word must not shift, the next cycle reloads).
    always_comb begin
        in_ctrl_all_seg = 1'b0;
        hold_all_seg    = 1'b1;
        out_valid       = 1'b0;
        frame_done      = 1'b0;
        if (!abort) begin
            case (r_state)
                c_st_load: begin
                    in_ctrl_all_seg = 1'b1;
                    hold_all_seg    = 1'b0;
                end
                c_st_shift: begin
                    out_valid    = 1'b1;
                    hold_all_seg = !(out_ready && !w_word_tc);
                end
                c_st_done: begin
                    frame_done = 1'b1;
                end
                default: begin
                    in_ctrl_all_seg = 1'b0;
                end
            endcase
        end
    end

    // Status outputs.
    always_comb begin
        busy    = (r_state != c_st_idle);
        mode    = r_mode;
        grp_idx = w_grp_cnt;
    end

endmodule : output_sequencer
`default_nettype wire

// File: doc/output_sequencer.md
OUTPUT_SEQUENCER -- requirements
Module: output_sequencer

Interface
REQ-001 Parameter NUM_SEG, default 8, words per group; equals the depth of the output shift chain.
REQ-002 Parameter NUM_GRP, default 8, groups per 64-point frame.
REQ-003 clk  in  1  sole clock, rising-edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  frame of results ready upstream; sampled only in IDLE.
REQ-006 mode_in  in  1  FFT(0)/IFFT(1) selection for the frame.
REQ-007 abort  in  1  synchronous cancel of the current frame.
REQ-008 out_ready  in  1  downstream accepts Q this cycle.
REQ-009 in_ctrl_all_seg  out  1  parallel-load select to the output chain.
REQ-010 hold_all_seg  out  1  freeze the output chain.
REQ-011 mode  out  1  latched mode, drives the swap/scale stage.
REQ-012 out_valid  out  1  Q of the output chain is a valid result word.
REQ-013 grp_idx  out  3  group whose eight words the upstream must present on D1..D8.
REQ-014 busy  out  1  frame in progress.
REQ-015 frame_done  out  1  one-cycle pulse after the last word is accepted.

Function
REQ-016 The FSM SHALL have four states: IDLE, LOAD, SHIFT and DONE.
REQ-017 IDLE: hold_all_seg=1, in_ctrl_all_seg=0; start=1 -> LOAD, mode<=mode_in, grp_idx<=0.
REQ-018 LOAD: the FSM SHALL stay here exactly one cycle with in_ctrl_all_seg=1, hold_all_seg=0, out_valid=0, then go to SHIFT with word_cnt<=0.
REQ-019 SHIFT: out_valid=1 and in_ctrl_all_seg=0.
REQ-020 SHIFT with out_ready=0: hold_all_seg=1, and Q and all counters SHALL stay unchanged.
REQ-021 SHIFT, out_ready=1, word_cnt<NUM_SEG-1: hold_all_seg=0 (chain shifts one place), word_cnt+1.
REQ-022 SHIFT, out_ready=1, word_cnt=NUM_SEG-1, grp_idx<NUM_GRP-1: hold_all_seg=1, grp_idx+1, -> LOAD.
REQ-023 SHIFT, out_ready=1, word_cnt=NUM_SEG-1, grp_idx=NUM_GRP-1: hold_all_seg=1, -> DONE.
REQ-024 DONE: frame_done=1 for one cycle, hold_all_seg=1, -> IDLE.
REQ-025 Latency: with out_ready held at 1, start at cycle 0 gives LOAD at cycle 1+9g and words at cycles 2+9g..9+9g for group g, and frame_done at cycle 73.
REQ-026 abort=1 in any state SHALL force IDLE at the next edge. In the abort cycle: hold_all_seg=1, in_ctrl_all_seg=0, out_valid=0. abort SHALL take priority over start and out_ready.
REQ-027 start while busy SHALL be ignored; mode SHALL NOT change until the next IDLE->LOAD transition.
REQ-028 busy SHALL be 1 whenever the state is not IDLE.
REQ-029 out_valid, in_ctrl_all_seg, hold_all_seg and frame_done SHALL decode from state and inputs only; there is no extra pipeline stage.
REQ-030 word_cnt and grp_idx SHALL be 3-bit counters that never wrap inside a frame; both SHALL clear on the IDLE->LOAD transition.

Reset
REQ-031 While rst=0: state=IDLE, hold_all_seg=1, in_ctrl_all_seg=0, mode=0, out_valid=0, grp_idx=0, word_cnt=0, busy=0, frame_done=0.
REQ-032 Reset asserted mid-frame SHALL apply immediately without waiting for clk. The first post-reset cycle SHALL behave as IDLE.

Structure
REQ-033 Package fft_out_pkg SHALL hold the state encoding, NUM_SEG/NUM_GRP defaults and the counter width constant.
REQ-034 The word and group counters SHALL be one reusable sub-module, mod_counter (enable, clear, terminal-count flag), instantiated twice.

Verification
REQ-035 rst low then high, start=1 for one cycle, mode_in=1, out_ready=1 -> 8 LOAD pulses at cycles 1,10,...,64, out_valid for 64 cycles, frame_done at cycle 73, mode=1 throughout.
REQ-036 out_ready=0 for 3 cycles at word_cnt=4 of group 2 -> hold_all_seg=1 and out_valid=1 over those cycles, Q stable, word_cnt stays 4, frame_done delayed by 3 cycles.
REQ-037 abort=1 during SHIFT of group 5 -> next cycle IDLE, busy=0, out_valid=0, no frame_done; a new start then restarts at grp_idx=0.
REQ-038 start pulsed during SHIFT with mode_in toggled -> ignored, mode unchanged, frame completes normally.
REQ-039 rst driven low asynchronously mid-LOAD -> all outputs at reset values before the next clk edge.
REQ-040 start and abort both high in IDLE -> FSM stays IDLE, mode not latched.
